// File: rtl/rr_storage_buf_sched.sv
// rtl/rr_storage_buf_sched.sv - record-mode writeback buffer scheduler
module rr_storage_buf_sched #(
    parameter int ADDR_WIDTH = 64,
    parameter int SIZE_WIDTH = 32,
    parameter int BEAT_BYTES = 64,
    parameter int DESC_DEPTH = 4,
    parameter int CPL_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              desc_valid,
    output logic                              desc_ready,
    input  logic [ADDR_WIDTH-1:0]             desc_addr,
    input  logic [SIZE_WIDTH-1:0]             desc_size,
    output logic [ADDR_WIDTH-1:0]             wb_buf_addr,
    output logic [SIZE_WIDTH-1:0]             wb_buf_size,
    output logic                              wb_buf_update,
    input  logic                              wb_beat_done,
    output logic                              wb_force_finish,
    input  logic                              wb_idle,
    input  logic                              record_finish,
    output logic                              cpl_valid,
    input  logic                              cpl_ready,
    output logic [ADDR_WIDTH-1:0]             cpl_addr,
    output logic [SIZE_WIDTH-1:0]             cpl_bytes,
    output logic                              cpl_last,
    output logic                              irq,
    output logic                              rec_stall,
    output logic                              err_bad_desc,
    output logic                              err_overrun,
    output logic [$clog2(DESC_DEPTH+1)-1:0]   desc_count
);
    localparam int BLOG = $clog2(BEAT_BYTES);
    localparam int BCW  = SIZE_WIDTH - BLOG;
    localparam int DPW  = $clog2(DESC_DEPTH);
    localparam int DCW  = $clog2(DESC_DEPTH + 1);
    localparam int CPW  = $clog2(CPL_DEPTH);
    localparam int CCW  = $clog2(CPL_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, LOAD, ACTIVE, RETIRE, FLUSH, DONE} state_t;
    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] dq_addr_q [DESC_DEPTH];
    logic [SIZE_WIDTH-1:0] dq_size_q [DESC_DEPTH];
    logic [DPW-1:0]        dq_wr_q, dq_rd_q;
    logic [DCW-1:0]        dq_cnt_q;

    logic [ADDR_WIDTH-1:0] cq_addr_q  [CPL_DEPTH];
    logic [SIZE_WIDTH-1:0] cq_bytes_q [CPL_DEPTH];
    logic                  cq_last_q  [CPL_DEPTH];
    logic [CPW-1:0]        cq_wr_q, cq_rd_q;
    logic [CCW-1:0]        cq_cnt_q;

    logic [ADDR_WIDTH-1:0] act_addr_q, act_addr_d;
    logic [SIZE_WIDTH-1:0] act_size_q, act_size_d;
    logic [BCW-1:0]        beat_cnt_q, beat_cnt_d, beat_inc;
    logic                  fin_pend_q, fin_pend_d;

    logic wb_buf_update_q, wb_force_finish_q, irq_q, rec_stall_q;
    logic err_bad_desc_q, err_overrun_q;

    logic                  desc_acc, desc_good, desc_push, desc_pop;
    logic                  cq_pop, cq_space, cq_push;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic [SIZE_WIDTH-1:0] push_bytes;
    logic                  push_last;
    logic                  beat_live;

    assign desc_ready = (dq_cnt_q != DCW'(DESC_DEPTH));
    assign desc_acc   = desc_valid && desc_ready;
    assign desc_good  = (desc_size != '0) && (desc_size[BLOG-1:0] == '0) &&
                        (desc_addr[BLOG-1:0] == '0);
    assign desc_push  = desc_acc && desc_good;

    assign cpl_valid = (cq_cnt_q != '0);
    assign cq_pop    = cpl_valid && cpl_ready;
    assign cq_space  = (cq_cnt_q != CCW'(CPL_DEPTH)) || cq_pop;
    assign cpl_addr  = cpl_valid ? cq_addr_q[cq_rd_q]  : '0;
    assign cpl_bytes = cpl_valid ? cq_bytes_q[cq_rd_q] : '0;
    assign cpl_last  = cpl_valid ? cq_last_q[cq_rd_q]  : 1'b0;

    assign beat_inc  = beat_cnt_q + BCW'(1);
    assign beat_live = (state_q == ACTIVE) || (state_q == FLUSH);

    always_comb begin
        state_d    = state_q;
        act_addr_d = act_addr_q;
        act_size_d = act_size_q;
        beat_cnt_d = beat_cnt_q;
        fin_pend_d = fin_pend_q;
        desc_pop   = 1'b0;
        cq_push    = 1'b0;
        push_addr  = '0;
        push_bytes = '0;
        push_last  = 1'b0;
        case (state_q)
            IDLE: begin
                // A pending flush with no buffer loaded retires as an empty last completion
                if (fin_pend_q || record_finish) begin
                    fin_pend_d = 1'b1;
                    if (cq_space) begin
                        cq_push    = 1'b1;
                        push_last  = 1'b1;
                        fin_pend_d = 1'b0;
                        state_d    = DONE;
                    end
                end else if (dq_cnt_q != '0) begin
                    desc_pop   = 1'b1;
                    act_addr_d = dq_addr_q[dq_rd_q];
                    act_size_d = dq_size_q[dq_rd_q];
                    beat_cnt_d = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (record_finish) fin_pend_d = 1'b1;
                state_d = ACTIVE;
            end
            ACTIVE: begin
                if (wb_beat_done) beat_cnt_d = beat_inc;
                if (wb_beat_done && ({beat_inc, {BLOG{1'b0}}} == act_size_q)) begin
                    if (record_finish) fin_pend_d = 1'b1;
                    state_d = RETIRE;
                end else if (record_finish || fin_pend_q) begin
                    fin_pend_d = 1'b0;
                    state_d    = FLUSH;
                end
            end
            RETIRE: begin
                if (record_finish) fin_pend_d = 1'b1;
                if (cq_space) begin
                    cq_push    = 1'b1;
                    push_addr  = act_addr_q;
                    push_bytes = {beat_cnt_q, {BLOG{1'b0}}};
                    state_d    = IDLE;
                end
            end
            FLUSH: begin
                if (wb_beat_done) beat_cnt_d = beat_inc;
                // wb_idle is ignored during the strobe cycle itself
                if (!wb_force_finish_q && wb_idle && cq_space) begin
                    cq_push    = 1'b1;
                    push_addr  = act_addr_q;
                    push_bytes = {beat_cnt_d, {BLOG{1'b0}}};
                    push_last  = 1'b1;
                    state_d    = DONE;
                end
            end
            default: state_d = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (desc_push) begin
            dq_addr_q[dq_wr_q] <= desc_addr;
            dq_size_q[dq_wr_q] <= desc_size;
        end
        if (cq_push) begin
            cq_addr_q[cq_wr_q]  <= push_addr;
            cq_bytes_q[cq_wr_q] <= push_bytes;
            cq_last_q[cq_wr_q]  <= push_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            dq_wr_q           <= '0;
            dq_rd_q           <= '0;
            dq_cnt_q          <= '0;
            cq_wr_q           <= '0;
            cq_rd_q           <= '0;
            cq_cnt_q          <= '0;
            act_addr_q        <= '0;
            act_size_q        <= '0;
            beat_cnt_q        <= '0;
            fin_pend_q        <= 1'b0;
            wb_buf_update_q   <= 1'b0;
            wb_force_finish_q <= 1'b0;
            irq_q             <= 1'b0;
            rec_stall_q       <= 1'b1;
            err_bad_desc_q    <= 1'b0;
            err_overrun_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            act_addr_q <= act_addr_d;
            act_size_q <= act_size_d;
            beat_cnt_q <= beat_cnt_d;
            fin_pend_q <= fin_pend_d;

            if (desc_push) dq_wr_q <= dq_wr_q + DPW'(1);
            if (desc_pop)  dq_rd_q <= dq_rd_q + DPW'(1);
            case ({desc_push, desc_pop})
                2'b10:   dq_cnt_q <= dq_cnt_q + DCW'(1);
                2'b01:   dq_cnt_q <= dq_cnt_q - DCW'(1);
                default: ;
            endcase

            if (cq_push) cq_wr_q <= cq_wr_q + CPW'(1);
            if (cq_pop)  cq_rd_q <= cq_rd_q + CPW'(1);
            case ({cq_push, cq_pop})
                2'b10:   cq_cnt_q <= cq_cnt_q + CCW'(1);
                2'b01:   cq_cnt_q <= cq_cnt_q - CCW'(1);
                default: ;
            endcase

            wb_buf_update_q   <= (state_d == LOAD);
            wb_force_finish_q <= (state_d == FLUSH) && (state_q != FLUSH);
            irq_q             <= cq_push;
            rec_stall_q       <= !((state_d == ACTIVE) || (state_d == FLUSH));
            if (desc_acc && !desc_good)    err_bad_desc_q <= 1'b1;
            if (wb_beat_done && !beat_live) err_overrun_q  <= 1'b1;
        end
    end

    assign wb_buf_addr     = act_addr_q;
    assign wb_buf_size     = act_size_q;
    assign wb_buf_update   = wb_buf_update_q;
    assign wb_force_finish = wb_force_finish_q;
    assign irq             = irq_q;
    assign rec_stall       = rec_stall_q;
    assign err_bad_desc    = err_bad_desc_q;
    assign err_overrun     = err_overrun_q;
    assign desc_count      = dq_cnt_q;

endmodule

// File: tb/tb_rr_storage_buf_sched.sv
// tb/tb_rr_storage_buf_sched.sv - scoreboard bench for rr_storage_buf_sched
module tb_rr_storage_buf_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        desc_valid, desc_ready;
    logic [63:0] desc_addr;
    logic [31:0] desc_size;
    logic [63:0] wb_buf_addr;
    logic [31:0] wb_buf_size;
    logic        wb_buf_update, wb_beat_done, wb_force_finish, wb_idle, record_finish;
    logic        cpl_valid, cpl_ready, cpl_last, irq, rec_stall, err_bad_desc, err_overrun;
    logic [63:0] cpl_addr;
    logic [31:0] cpl_bytes;
    logic [2:0]  desc_count;

    always #5 clk = ~clk;

    rr_storage_buf_sched dut (
        .clk(clk), .rst(rst),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_addr(desc_addr), .desc_size(desc_size),
        .wb_buf_addr(wb_buf_addr), .wb_buf_size(wb_buf_size),
        .wb_buf_update(wb_buf_update), .wb_beat_done(wb_beat_done),
        .wb_force_finish(wb_force_finish), .wb_idle(wb_idle),
        .record_finish(record_finish),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
        .cpl_addr(cpl_addr), .cpl_bytes(cpl_bytes), .cpl_last(cpl_last),
        .irq(irq), .rec_stall(rec_stall),
        .err_bad_desc(err_bad_desc), .err_overrun(err_overrun),
        .desc_count(desc_count)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] bytes;
        logic        last;
    } cpl_t;

    cpl_t exp_q[$];
    cpl_t mon_e;
    int   n_chk = 0, n_fail = 0;
    int   irq_cnt = 0, upd_cnt = 0, ff_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (irq) irq_cnt++;
            if (wb_buf_update) upd_cnt++;
            if (wb_force_finish) ff_cnt++;
            if (cpl_valid && cpl_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL cpl_unexpected: got addr 0x%0h bytes %0d last %0b, expected no completion",
                             cpl_addr, cpl_bytes, cpl_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("cpl_addr", cpl_addr, mon_e.addr);
                    chk("cpl_bytes", 64'(cpl_bytes), 64'(mon_e.bytes));
                    chk("cpl_last", 64'(cpl_last), 64'(mon_e.last));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        desc_valid = 1'b0; desc_addr = '0; desc_size = '0;
        wb_beat_done = 1'b0; wb_idle = 1'b1; record_finish = 1'b0; cpl_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_q.delete();
        irq_cnt = 0; upd_cnt = 0; ff_cnt = 0;
    endtask

    task automatic push_desc(input logic [63:0] a, input logic [31:0] s);
        int n = 0;
        desc_valid = 1'b1; desc_addr = a; desc_size = s;
        while (!desc_ready && n < 20) begin tick(); n++; end
        if (!desc_ready) begin
            n_chk++; n_fail++;
            $display("FAIL push_desc_timeout: desc_ready=0, expected 1");
        end
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic wait_active();
        int n = 0;
        while (rec_stall && n < 20) begin tick(); n++; end
        if (rec_stall) begin
            n_chk++; n_fail++;
            $display("FAIL wait_active_timeout: rec_stall=1, expected 0");
        end
    endtask

    task automatic beat();
        wb_beat_done = 1'b1;
        tick();
        wb_beat_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        chk("rst_desc_ready", desc_ready, 1);
        chk("rst_rec_stall", rec_stall, 1);
        chk("rst_cpl_valid", cpl_valid, 0);
        chk("rst_irq", irq, 0);
        chk("rst_update", wb_buf_update, 0);
        chk("rst_force", wb_force_finish, 0);
        chk("rst_err_bad", err_bad_desc, 0);
        chk("rst_err_ovr", err_overrun, 0);
        chk("rst_desc_count", desc_count, 0);
        chk("rst_cpl_addr", cpl_addr, 0);

        // two buffers, three beats
        desc_valid = 1'b1; desc_addr = 64'h1000_0000; desc_size = 128;
        tick();
        chk("t1_no_update_yet", wb_buf_update, 0);
        desc_addr = 64'h2000_0000; desc_size = 64;
        tick();
        desc_valid = 1'b0;
        chk("t1_update_lat2", wb_buf_update, 1);
        chk("t1_update_addr", wb_buf_addr, 64'h1000_0000);
        chk("t1_update_size", wb_buf_size, 128);
        exp_q.push_back('{addr: 64'h1000_0000, bytes: 128, last: 1'b0});
        exp_q.push_back('{addr: 64'h2000_0000, bytes: 64, last: 1'b0});
        wait_active();
        beat();
        beat();
        wait_active();
        chk("t1_b_addr", wb_buf_addr, 64'h2000_0000);
        beat();
        repeat (6) tick();
        chk("t1_irq_cnt", irq_cnt, 2);
        chk("t1_upd_cnt", upd_cnt, 2);
        chk("t1_rec_stall", rec_stall, 1);
        chk("t1_sb_empty", exp_q.size(), 0);

        // rejected descriptors
        do_reset();
        push_desc(64'h1000, 100);
        push_desc(64'h2000, 0);
        push_desc(64'h1020, 64);
        repeat (4) tick();
        chk("t2_desc_count", desc_count, 0);
        chk("t2_err_bad", err_bad_desc, 1);
        chk("t2_upd_cnt", upd_cnt, 0);

        // flush with a pending beat and a slow idle
        do_reset();
        wb_idle = 1'b0;
        exp_q.push_back('{addr: 64'h3000_0000, bytes: 128, last: 1'b1});
        push_desc(64'h3000_0000, 256);
        wait_active();
        beat();
        record_finish = 1'b1;
        tick();
        record_finish = 1'b0;
        chk("t3_force", wb_force_finish, 1);
        beat();
        chk("t3_force_once", wb_force_finish, 0);
        repeat (4) tick();
        chk("t3_no_cpl_while_busy", cpl_valid, 0);
        wb_idle = 1'b1;
        repeat (3) tick();
        push_desc(64'h4000_0000, 64);
        repeat (6) tick();
        chk("t3_desc_queued", desc_count, 1);
        chk("t3_upd_cnt", upd_cnt, 1);
        chk("t3_ff_cnt", ff_cnt, 1);
        chk("t3_irq_cnt", irq_cnt, 1);
        chk("t3_rec_stall", rec_stall, 1);
        chk("t3_sb_empty", exp_q.size(), 0);

        // completion queue backpressure
        do_reset();
        cpl_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('{addr: 64'h5000_0000 + 64'(i) * 64'h1000, bytes: 64, last: 1'b0});
            push_desc(64'h5000_0000 + 64'(i) * 64'h1000, 64);
            wait_active();
            beat();
        end
        repeat (4) tick();
        chk("t4_irq_cnt4", irq_cnt, 4);
        chk("t4_rec_stall", rec_stall, 1);
        chk("t4_cpl_head", cpl_addr, 64'h5000_0000);
        cpl_ready = 1'b1;
        tick();
        cpl_ready = 1'b0;
        chk("t4_irq_after_pop", irq, 1);
        tick();
        cpl_ready = 1'b1;
        repeat (6) tick();
        chk("t4_irq_cnt5", irq_cnt, 5);
        chk("t4_sb_empty", exp_q.size(), 0);

        // overrun, then final beat with coincident finish
        do_reset();
        beat();
        chk("t5_err_ovr", err_overrun, 1);
        repeat (3) tick();
        chk("t5_no_cpl", cpl_valid, 0);
        push_desc(64'h6000_0000, 128);
        wait_active();
        beat();
        exp_q.push_back('{addr: 64'h6000_0000, bytes: 128, last: 1'b0});
        exp_q.push_back('{addr: 64'h0, bytes: 0, last: 1'b1});
        wb_beat_done = 1'b1; record_finish = 1'b1;
        tick();
        wb_beat_done = 1'b0; record_finish = 1'b0;
        repeat (8) tick();
        chk("t5_irq_cnt", irq_cnt, 2);
        chk("t5_sb_empty", exp_q.size(), 0);

        // reset mid-buffer
        do_reset();
        push_desc(64'h7000_0000, 512);
        wait_active();
        repeat (3) beat();
        push_desc(64'h7100_0000, 64);
        chk("t6_pre_count", desc_count, 1);
        rst = 1'b1;
        tick();
        chk("t6_desc_ready", desc_ready, 1);
        chk("t6_desc_count", desc_count, 0);
        chk("t6_rec_stall", rec_stall, 1);
        chk("t6_buf_addr", wb_buf_addr, 0);
        chk("t6_buf_size", wb_buf_size, 0);
        chk("t6_cpl_valid", cpl_valid, 0);
        chk("t6_err_ovr", err_overrun, 0);
        rst = 1'b0;
        exp_q.push_back('{addr: 64'h7200_0000, bytes: 64, last: 1'b0});
        push_desc(64'h7200_0000, 64);
        wait_active();
        beat();
        repeat (5) tick();
        chk("t6_sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rr_storage_buf_sched.md
Name: rr_storage_buf_sched

Overview:
- Scheduler for the record-mode writeback buffer in the storage backend.
- Host software posts PCIM destination buffers as descriptors (address, size) through the CSR path; the block queues them.
- It feeds one buffer at a time to the writeback engine (buf_addr/buf_size/buf_update) and counts the 512-bit beats written into it.
- It retires each filled or flushed buffer into a completion queue read by CSR/host, raises an interrupt per retirement, and sequences the end-of-record flush.

Parameters:
ADDR_WIDTH, 64, host buffer address width
SIZE_WIDTH, 32, buffer size field width in bytes
BEAT_BYTES, 64, bytes per writeback AXI beat (512-bit bus)
DESC_DEPTH, 4, descriptor queue entries (power of 2)
CPL_DEPTH, 4, completion queue entries (power of 2)

Ports:
clk  in  1  clock; all logic in this single domain
rst  in  1  synchronous reset, active-high
desc_valid  in  1  descriptor offer
desc_ready  out  1  descriptor queue not full
desc_addr  in  ADDR_WIDTH  buffer base, BEAT_BYTES aligned
desc_size  in  SIZE_WIDTH  buffer bytes
wb_buf_addr  out  ADDR_WIDTH  to writeback write_buf_addr
wb_buf_size  out  SIZE_WIDTH  to writeback write_buf_size
wb_buf_update  out  1  one-cycle load strobe to writeback
wb_beat_done  in  1  one beat (BEAT_BYTES) accepted on AXI W by writeback
wb_force_finish  out  1  one-cycle flush request to writeback record_finish
wb_idle  in  1  writeback has no outstanding data/response
record_finish  in  1  pulse: recording ended, flush
cpl_valid  out  1  completion available
cpl_ready  in  1  completion pop
cpl_addr  out  ADDR_WIDTH  retired buffer base
cpl_bytes  out  SIZE_WIDTH  bytes written into it
cpl_last  out  1  completion produced by the flush
irq  out  1  one-cycle pulse per retirement
rec_stall  out  1  high whenever no buffer is loaded (ACTIVE not reached)
err_bad_desc  out  1  sticky: rejected descriptor
err_overrun  out  1  sticky: beat with no active buffer
desc_count  out  $clog2(DESC_DEPTH+1)  queued descriptors

Behaviour:
- Reset: all outputs 0 except desc_ready=1 and rec_stall=1. Both queues empty, counters 0, FSM=IDLE. Reset mid-operation discards all state, including a pending flush.
- Descriptor intake: accepted on desc_valid&desc_ready.
  - size==0 or size%BEAT_BYTES!=0 or addr%BEAT_BYTES!=0: handshake completes, entry dropped, err_bad_desc set.
  - desc_ready=0 when the queue holds DESC_DEPTH entries; a same-cycle pop does not raise it that cycle.
- FSM states:
  - IDLE: on queue non-empty, pop the head into active regs (addr, size, beat_cnt=0) -> LOAD.
  - LOAD: wb_buf_update=1 for exactly one cycle, with wb_buf_addr/size valid the same cycle -> ACTIVE. Latency from acceptance into an empty queue while IDLE to the update strobe is 2 cycles.
  - ACTIVE: each wb_beat_done increments beat_cnt. When beat_cnt*BEAT_BYTES reaches size on an edge -> RETIRE. A record_finish seen in ACTIVE -> FLUSH.
  - RETIRE: wait until the completion queue is not full, then push {addr, beat_cnt*BEAT_BYTES, last=0}, pulse irq -> IDLE. rec_stall stays high while waiting.
  - FLUSH: wb_force_finish=1 in the entry cycle only. Keep counting beats. On wb_idle=1 (checked from the cycle after the strobe), push {addr, bytes, last=1} when space allows, pulse irq -> DONE.
  - DONE: terminal until rst. Descriptors are still queued; no loads.
- record_finish while IDLE/LOAD/RETIRE: latched. Applied after the current retire completes or load completes.
  - From IDLE with no active buffer: push completion {addr=0, bytes=0, last=1}, irq -> DONE.
- Simultaneous final beat and record_finish: the normal retire takes precedence (last=0), then the latched finish is applied from IDLE (zero-byte last completion).
- wb_beat_done outside ACTIVE/FLUSH: ignored, err_overrun set.
- A beat that would exceed size cannot occur: retirement is on the filling edge and the writeback holds until the next update.
- Byte arithmetic: beat_cnt is SIZE_WIDTH-$clog2(BEAT_BYTES) bits; bytes = beat_cnt shifted left by $clog2(BEAT_BYTES).
- Completion queue: FWFT. cpl_* are valid whenever cpl_valid=1; popped on cpl_valid&cpl_ready. Push and pop in the same cycle are allowed when full.

Test Plan:
- Push (0x1000_0000,128) then (0x2000_0000,64); drive 3 single beats -> update strobe 2 cycles after first accept with addr 0x1000_0000 size 128; completions (0x1000_0000,128,last0) and (0x2000_0000,64,last0); 2 irq pulses; rec_stall high after the second retire.
- Push size 100, then size 0, then addr 0x1020 -> all handshakes complete, desc_count stays 0, err_bad_desc=1, no update strobe.
- Load (0x3000_0000,256), 1 beat, record_finish, 1 more beat, hold wb_idle=0 for 5 cycles then 1 -> force_finish pulse once, completion (0x3000_0000,128,last1), FSM DONE, a later descriptor is queued but never loaded.
- cpl_ready=0, five 64-byte buffers each filled by one beat -> 4 completions queued, 5th buffer held in RETIRE with rec_stall=1 and no 5th irq; one pop -> 5th completion pushed next cycle.
- Beat with empty descriptor queue -> err_overrun=1, no completion. Final beat and record_finish in the same cycle -> completion (addr,size,last0) followed by (0,0,last1).
- Assert rst while ACTIVE with beat_cnt=3 -> next cycle all outputs at reset values, desc_ready=1, desc_count=0.
